lupdate: RTL

// Beacon update stage directly downstream of the beacon report stage in the UM pipeline. Forwards the
// 134-bit packet stream with a fixed 3-cycle latency. Detects CNC beacon update messages addressed to this

---
 rtl/lupdate.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/lupdate.sv
`default_nettype none
// ============================================================================
// Module   : lupdate
// Purpose  : Beacon update stage. Forwards the 134-bit packet stream with a
//            fixed 3-cycle latency, strips CNC beacon update messages that
//            are addressed to this switch, and commits their fields into the
//            live beacon configuration registers.
// Revision : 1.0 - initial release
// ============================================================================
module lupdate #(
    parameter logic [7:0]  LMID           = 8'd12,
    parameter logic [3:0]  UPD_MSG_TYPE   = 4'hd,
    parameter logic        DEF_DIRECTION  = 1'b0,
    parameter logic [15:0] DEF_TB_PARA    = 16'd1,
    parameter logic [15:0] DEF_TB_DEPTH   = 16'd64,
    parameter logic [47:0] DEF_DIRECT_MAC = 48'h0,
    parameter logic [31:0] DEF_TS_PERIOD  = 32'd65536
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_lu_data_wr,
    input  logic [133:0] in_lu_data,
    input  logic         in_lu_data_valid,
    input  logic         in_lu_data_valid_wr,
    input  logic [47:0]  in_local_mac_id,
    output logic         out_lu_data_wr,
    output logic [133:0] out_lu_data,
    output logic         out_lu_data_valid,
    output logic         out_lu_data_valid_wr,
    output logic         beacon_update_master,
    output logic         direction,
    output logic [15:0]  token_bucket_para,
    output logic [15:0]  token_bucket_depth,
    output logic [47:0]  direct_mac_addr,
    output logic [31:0]  time_slot_period,
    output logic [31:0]  lu_update_cnt
);

    // Beat type codes carried in in_lu_data[133:132]
    localparam logic [1:0]  c_KIND_HEAD  = 2'b01;
    localparam logic [1:0]  c_KIND_TAIL  = 2'b10;
    localparam logic [15:0] c_PTP_ETYPE  = 16'h88f7;
    localparam logic [3:0]  c_CLASS_BEAT = 4'd2;
    localparam logic [3:0]  c_CFG_BEAT   = 4'd6;
    localparam logic [3:0]  c_BCNT_MAX   = 4'd15;

    // This stage carries no module-ID addressed traffic; LMID is kept so the
    // stage can be identified in the pipeline map without a port change.
    if (LMID == 8'd0) begin : g_lmid_unassigned
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_FWD  = 2'd2,
        S_UPD  = 2'd3
    } state_t;

    state_t       r_state;
    logic [3:0]   r_bcnt;
    logic         r_shadow_ok;
    logic [47:0]  r_sh_mac;
    logic         r_sh_dir;
    logic [15:0]  r_sh_depth;
    logic [15:0]  r_sh_para;
    logic [31:0]  r_sh_period;

    // Pipeline stage registers
    logic         r_p1_wr,  r_p2_wr;
    logic [133:0] r_p1_data, r_p2_data;
    logic         r_p1_v,   r_p2_v;
    logic         r_p1_vwr, r_p2_vwr;
    logic         r_p1_drop, r_p2_drop;

    logic         r_out_wr;
    logic [133:0] r_out_data;
    logic         r_out_v;
    logic         r_out_vwr;

    // Live configuration
    logic         r_master;
    logic         r_dir;
    logic [15:0]  r_para;
    logic [15:0]  r_depth;
    logic [47:0]  r_mac;
    logic [31:0]  r_period;
    logic [31:0]  r_cnt;

    // Beat decode
    logic         w_head;
    logic         w_tail;
    logic         w_body;
    logic [3:0]   w_bcnt;
    logic         w_is_upd;
    logic         w_classify;
    logic         w_set_drop;
    logic         w_in_drop;
    logic         w_cap;
    logic         w_shadow_ok;
    logic         w_commit;
    logic         w_out_drop;

    // Values committed on the tail; a tail landing on the config beat itself
    // takes the fields straight from the bus.
    logic [47:0]  w_cm_mac;
    logic         w_cm_dir;
    logic [15:0]  w_cm_depth;
    logic [15:0]  w_cm_para;
    logic [31:0]  w_cm_period;

    assign w_head = in_lu_data_wr && (in_lu_data[133:132] == c_KIND_HEAD);
    assign w_tail = in_lu_data_wr && (in_lu_data[133:132] == c_KIND_TAIL);
    assign w_body = in_lu_data_wr && !w_head;

    // Index of the beat currently on the input bus
    assign w_bcnt = w_head ? 4'd0 : r_bcnt;

    assign w_is_upd = (in_lu_data[127:80] == in_local_mac_id) &&
                      (in_lu_data[31:16]  == c_PTP_ETYPE) &&
                      (in_lu_data[11:8]   == UPD_MSG_TYPE);

    assign w_classify = w_body && (r_state == S_HDR) && (w_bcnt == c_CLASS_BEAT);
    assign w_set_drop = w_classify && w_is_upd;
    assign w_in_drop  = (w_body && (r_state == S_UPD)) || w_set_drop;

    assign w_cap       = w_body && (r_state == S_UPD) && (w_bcnt == c_CFG_BEAT);
    assign w_shadow_ok = r_shadow_ok || w_cap;
    assign w_commit    = w_tail && (r_state == S_UPD) && w_shadow_ok &&
                         in_lu_data_valid_wr && in_lu_data_valid;

    assign w_cm_mac    = w_cap ? in_lu_data[127:80] : r_sh_mac;
    assign w_cm_dir    = w_cap ? in_lu_data[79]     : r_sh_dir;
    assign w_cm_depth  = w_cap ? in_lu_data[63:48]  : r_sh_depth;
    assign w_cm_para   = w_cap ? in_lu_data[47:32]  : r_sh_para;
    assign w_cm_period = w_cap ? in_lu_data[31:0]   : r_sh_period;

    // The beat in p2 leaves this cycle, so it also needs the late drop tag
    assign w_out_drop = r_p2_drop || w_set_drop;

    // Packet classifier: beat counter, state, and update shadow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_bcnt      <= 4'd0;
            r_shadow_ok <= 1'b0;
            r_sh_mac    <= 48'd0;
            r_sh_dir    <= 1'b0;
            r_sh_depth  <= 16'd0;
            r_sh_para   <= 16'd0;
            r_sh_period <= 32'd0;
        end else begin
            if (in_lu_data_wr) begin
                r_bcnt <= (w_bcnt == c_BCNT_MAX) ? c_BCNT_MAX : w_bcnt + 4'd1;
            end
            if (w_head) begin
                // A head anywhere restarts classification and abandons any
                // half-received update.
                r_state     <= S_HDR;
                r_shadow_ok <= 1'b0;
            end else if (in_lu_data_wr) begin
                case (r_state)
                    S_IDLE: r_state <= S_IDLE;
                    S_HDR: begin
                        if (w_tail) begin
                            r_state <= S_IDLE;
                        end else if (w_classify) begin
                            r_state <= w_is_upd ? S_UPD : S_FWD;
                        end
                    end
                    S_FWD: begin
                        if (w_tail) begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_UPD: begin
                        if (w_cap) begin
                            r_shadow_ok <= 1'b1;
                            r_sh_mac    <= in_lu_data[127:80];
                            r_sh_dir    <= in_lu_data[79];
                            r_sh_depth  <= in_lu_data[63:48];
                            r_sh_para   <= in_lu_data[47:32];
                            r_sh_period <= in_lu_data[31:0];
                        end
                        if (w_tail) begin
                            r_state     <= S_IDLE;
                            r_shadow_ok <= 1'b0;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Three-stage forwarding pipeline; dropped beats leave as all-zero cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p1_wr    <= 1'b0;
            r_p1_data  <= '0;
            r_p1_v     <= 1'b0;
            r_p1_vwr   <= 1'b0;
            r_p1_drop  <= 1'b0;
            r_p2_wr    <= 1'b0;
            r_p2_data  <= '0;
            r_p2_v     <= 1'b0;
            r_p2_vwr   <= 1'b0;
            r_p2_drop  <= 1'b0;
            r_out_wr   <= 1'b0;
            r_out_data <= '0;
            r_out_v    <= 1'b0;
            r_out_vwr  <= 1'b0;
        end else begin
            r_p1_wr   <= in_lu_data_wr;
            r_p1_data <= in_lu_data;
            r_p1_v    <= in_lu_data_valid;
            r_p1_vwr  <= in_lu_data_valid_wr;
            r_p1_drop <= w_in_drop;

            r_p2_wr   <= r_p1_wr;
            r_p2_data <= r_p1_data;
            r_p2_v    <= r_p1_v;
            r_p2_vwr  <= r_p1_vwr;
            r_p2_drop <= r_p1_drop || w_set_drop;

            if (w_out_drop) begin
                r_out_wr   <= 1'b0;
                r_out_data <= '0;
                r_out_v    <= 1'b0;
                r_out_vwr  <= 1'b0;
            end else begin
                r_out_wr   <= r_p2_wr;
                r_out_data <= r_p2_data;
                r_out_v    <= r_p2_v;
                r_out_vwr  <= r_p2_vwr;
            end
        end
    end

    // Live beacon configuration, loaded only on a committed update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_master <= 1'b0;
            r_dir    <= DEF_DIRECTION;
            r_para   <= DEF_TB_PARA;
            r_depth  <= DEF_TB_DEPTH;
            r_mac    <= DEF_DIRECT_MAC;
            r_period <= DEF_TS_PERIOD;
            r_cnt    <= 32'd0;
        end else if (w_commit) begin
            r_master <= ~r_master;
            r_dir    <= w_cm_dir;
            r_para   <= w_cm_para;
            r_depth  <= w_cm_depth;
            r_mac    <= w_cm_mac;
            r_period <= w_cm_period;
            r_cnt    <= r_cnt + 32'd1;
        end
    end

    assign out_lu_data_wr       = r_out_wr;
    assign out_lu_data          = r_out_data;
    assign out_lu_data_valid    = r_out_v;
    assign out_lu_data_valid_wr = r_out_vwr;
    assign beacon_update_master = r_master;
    assign direction            = r_dir;
    assign token_bucket_para    = r_para;
    assign token_bucket_depth   = r_depth;
    assign direct_mac_addr      = r_mac;
    assign time_slot_period     = r_period;
    assign lu_update_cnt        = r_cnt;

endmodule
`default_nettype wire
